// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the external memory-mapped bus arbiter.
package riscv_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  rnw;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master that was not
// granted last wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = (&req_i) ? ~last_i : req_i[1];
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave arbiter with one outstanding transaction and registered
// slave-side outputs. Define ARB_TIMEOUT_EN to enable the wait-state timeout.
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 15
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_rnw_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic              m1_rnw_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_req_o,
    output logic              s_rnw_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    input  logic              s_ack_i,

    output logic              busy_o,
    output logic              owner_o
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              s_req_q, s_req_d;
    logic              s_rnw_q, s_rnw_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
`ifdef ARB_TIMEOUT_EN
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
`endif

    logic gnt_valid;
    logic gnt_id;

    rr_pick2 u_pick (
        .req_i       ({m1_req_i, m0_req_i}),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        s_req_d   = s_req_q;
        s_rnw_d   = s_rnw_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_d     = 1'b0;
        cnt_d     = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d   = gnt_id;
                    s_rnw_d   = (gnt_id == MASTER_DBG) ? m1_rnw_i   : m0_rnw_i;
                    s_addr_d  = (gnt_id == MASTER_DBG) ? m1_addr_i  : m0_addr_i;
                    s_wdata_d = (gnt_id == MASTER_DBG) ? m1_wdata_i : m0_wdata_i;
                    s_req_d   = 1'b1;
                    state_d   = REQ;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            REQ, WAIT: begin
                // A slave ack on the expiry cycle still wins over the timeout.
                if (s_ack_i) begin
                    s_req_d = 1'b0;
                    ack_d   = 1'b1;
                    rdata_d = s_rnw_q ? s_rdata_i : '0;
                    state_d = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q + 8'd1 >= 8'(TIMEOUT)) begin
                    s_req_d = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = WAIT;
                end
`else
                else begin
                    state_d = WAIT;
                end
`endif
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            owner_q   <= MASTER_CPU;
            last_q    <= MASTER_DBG;
            s_req_q   <= 1'b0;
            s_rnw_q   <= 1'b1;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            s_req_q   <= s_req_d;
            s_rnw_q   <= s_rnw_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
`ifdef ARB_TIMEOUT_EN
            err_q     <= err_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign owner_o   = owner_q;
    assign s_req_o   = s_req_q;
    assign s_rnw_o   = s_rnw_q;
    assign s_addr_o  = s_addr_q;
    assign s_wdata_o = s_wdata_q;

    // ack_q is only ever set in DONE, so gating by owner steers the pulse.
    assign m0_ack_o   = ack_q & (owner_q == MASTER_CPU);
    assign m1_ack_o   = ack_q & (owner_q == MASTER_DBG);
    assign m0_rdata_o = (owner_q == MASTER_CPU) ? rdata_q : '0;
    assign m1_rdata_o = (owner_q == MASTER_DBG) ? rdata_q : '0;

`ifdef ARB_TIMEOUT_EN
    assign m0_err_o = err_q & (owner_q == MASTER_CPU);
    assign m1_err_o = err_q & (owner_q == MASTER_DBG);
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_rnw, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_rnw, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_req, s_rnw, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        busy, owner;

    mem_bus_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0_req_i   (m0_req),
        .m0_rnw_i   (m0_rnw),
        .m0_addr_i  (m0_addr),
        .m0_wdata_i (m0_wdata),
        .m0_rdata_o (m0_rdata),
        .m0_ack_o   (m0_ack),
        .m0_err_o   (m0_err),
        .m1_req_i   (m1_req),
        .m1_rnw_i   (m1_rnw),
        .m1_addr_i  (m1_addr),
        .m1_wdata_i (m1_wdata),
        .m1_rdata_o (m1_rdata),
        .m1_ack_o   (m1_ack),
        .m1_err_o   (m1_err),
        .s_req_o    (s_req),
        .s_rnw_o    (s_rnw),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_rdata_i  (s_rdata),
        .s_ack_i    (s_ack),
        .busy_o     (busy),
        .owner_o    (owner)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 15;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: on a tie the master not served last wins.
    function automatic bit winner(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    // Transaction-level model: a request is either out on the slave, in its
    // single completion cycle, or the bus is free.
    bit          md_valid   = 1'b0;
    bit          md_tx      = 1'b0;
    bit          md_ack_cyc = 1'b0;
    bit          md_owner   = 1'b0;
    bit          md_last    = 1'b1;
    bit          md_err     = 1'b0;
    bit          md_rnw     = 1'b1;
    logic [31:0] md_addr    = '0;
    logic [31:0] md_wdata   = '0;
    logic [31:0] md_rdata   = '0;
    int          md_waited  = 0;

    always @(posedge clk) begin
        if (rst) begin
            md_valid   <= 1'b1;
            md_tx      <= 1'b0;
            md_ack_cyc <= 1'b0;
            md_owner   <= 1'b0;
            md_last    <= 1'b1;
            md_err     <= 1'b0;
        end else if (md_ack_cyc) begin
            md_ack_cyc <= 1'b0;
            md_last    <= md_owner;
        end else if (!md_tx) begin
            if (m0_req || m1_req) begin
                md_owner  <= winner(m0_req, m1_req, md_last);
                md_rnw    <= winner(m0_req, m1_req, md_last) ? m1_rnw : m0_rnw;
                md_addr   <= winner(m0_req, m1_req, md_last) ? m1_addr : m0_addr;
                md_wdata  <= winner(m0_req, m1_req, md_last) ? m1_wdata : m0_wdata;
                md_tx     <= 1'b1;
                md_waited <= 0;
            end
        end else if (s_ack) begin
            md_tx      <= 1'b0;
            md_ack_cyc <= 1'b1;
            md_err     <= 1'b0;
            md_rdata   <= md_rnw ? s_rdata : 32'h0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (md_waited + 1 >= TMO) begin
            md_tx      <= 1'b0;
            md_ack_cyc <= 1'b1;
            md_err     <= 1'b1;
            md_rdata   <= 32'h0;
        end else begin
            md_waited <= md_waited + 1;
        end
`endif
    end

    always @(negedge clk) begin
        if (md_valid) begin
            chk1("busy", busy, md_tx || md_ack_cyc);
            chk1("s_req", s_req, md_tx);
            chk1("owner", owner, md_owner);
            chk1("m0_ack", m0_ack, md_ack_cyc && !md_owner);
            chk1("m1_ack", m1_ack, md_ack_cyc && md_owner);
            chk1("m0_err", m0_err, md_ack_cyc && !md_owner && md_err);
            chk1("m1_err", m1_err, md_ack_cyc && md_owner && md_err);
            if (md_tx) begin
                chk1("s_rnw", s_rnw, md_rnw);
                chk32("s_addr", s_addr, md_addr);
                chk32("s_wdata", s_wdata, md_wdata);
            end
            if (md_ack_cyc && !md_owner) chk32("m0_rdata", m0_rdata, md_rdata);
            if (md_ack_cyc && md_owner) chk32("m1_rdata", m1_rdata, md_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sreq(input string tag, output bit ok);
        int k = 0;
        while (!s_req && k < 12) begin
            tick();
            k++;
        end
        ok = s_req;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: s_req got 0 required 1 within 12 cycles", tag);
        end
    endtask

    // Wait for a grant, check who got it and the address, ack at once.
    task automatic serve(input string tag, input bit exp_own, input logic [31:0] exp_addr);
        bit ok;
        wait_sreq(tag, ok);
        if (ok) begin
            chk1({tag, "_owner"}, owner, exp_own);
            chk32({tag, "_addr"}, s_addr, exp_addr);
            s_ack   = 1'b1;
            s_rdata = $urandom;
            tick();
            s_ack   = 1'b0;
            chk1({tag, "_ack"}, exp_own ? m1_ack : m0_ack, 1'b1);
            chk1({tag, "_other_ack"}, exp_own ? m0_ack : m1_ack, 1'b0);
        end
    endtask

    task automatic drive_m(input bit got_ack, inout logic req, inout logic rnw,
                           inout logic [31:0] addr, inout logic [31:0] wdata);
        if (req && got_ack) begin
            if ($urandom_range(0, 7) != 0) req = 1'b0;
        end else if (!req && $urandom_range(0, 3) == 0) begin
            req   = 1'b1;
            rnw   = 1'($urandom_range(0, 1));
            addr  = $urandom;
            wdata = $urandom;
        end else if (req && $urandom_range(0, 199) == 0) begin
            req = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int cnt;
        rst = 1'b1;
        m0_req = 1'b0; m0_rnw = 1'b1; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_rnw = 1'b1; m1_addr = '0; m1_wdata = '0;
        s_ack = 1'b0; s_rdata = '0;
        repeat (3) tick();

        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_s_req", s_req, 1'b0);
        chk1("rst_s_rnw", s_rnw, 1'b1);
        chk32("rst_s_addr", s_addr, 32'h0);
        chk32("rst_s_wdata", s_wdata, 32'h0);
        chk32("rst_m0_rdata", m0_rdata, 32'h0);
        chk1("rst_m0_ack", m0_ack, 1'b0);
        rst = 1'b0;

        // Zero-wait read
        m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 32'h8000_0010;
        tick();
        chk1("t1_s_req", s_req, 1'b1);
        chk32("t1_s_addr", s_addr, 32'h8000_0010);
        chk1("t1_s_rnw", s_rnw, 1'b1);
        s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
        tick();
        s_ack = 1'b0; s_rdata = '0;
        chk1("t1_m0_ack", m0_ack, 1'b1);
        chk32("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk1("t1_m1_ack", m1_ack, 1'b0);
        chk1("t1_s_req_low", s_req, 1'b0);
        m0_req = 1'b0;
        tick();
        chk1("t1_ack_pulse", m0_ack, 1'b0);
        chk1("t1_idle", busy, 1'b0);

        // Tie from reset, then alternation with both held
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m0_rnw = 1'b0; m0_addr = 32'h0000_1234; m0_wdata = 32'h0000_0055;
        m1_req = 1'b1; m1_rnw = 1'b1; m1_addr = 32'h0000_2000;
        serve("t2_first", 1'b0, 32'h0000_1234);
        chk32("t2_wr_rdata", m0_rdata, 32'h0);
        m0_req = 1'b0;
        serve("t2_second", 1'b1, 32'h0000_2000);
        m0_req = 1'b1;
        serve("t2_alt0", 1'b0, 32'h0000_1234);
        serve("t2_alt1", 1'b1, 32'h0000_2000);
        serve("t2_alt2", 1'b0, 32'h0000_1234);
        serve("t2_alt3", 1'b1, 32'h0000_2000);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) tick();

        // Five wait states on an M1 write
        m1_req = 1'b1; m1_rnw = 1'b0; m1_addr = 32'hA5A5_0004; m1_wdata = 32'h1357_9BDF;
        wait_sreq("t3_grant", ok);
        if (ok) begin
            for (int i = 0; i < 6; i++) begin
                chk1("t3_s_req", s_req, 1'b1);
                chk32("t3_s_addr", s_addr, 32'hA5A5_0004);
                chk32("t3_s_wdata", s_wdata, 32'h1357_9BDF);
                chk1("t3_no_early_ack", m1_ack, 1'b0);
                if (i == 5) s_ack = 1'b1;
                tick();
            end
            s_ack = 1'b0;
            chk1("t3_m1_ack", m1_ack, 1'b1);
            chk1("t3_m1_err", m1_err, 1'b0);
            m1_req = 1'b0;
            tick();
            chk1("t3_ack_pulse", m1_ack, 1'b0);
        end
        tick();

`ifdef ARB_TIMEOUT_EN
        m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 32'h0000_0040;
        wait_sreq("t4_grant", ok);
        cnt = 0;
        while (s_req && cnt < 40) begin
            cnt++;
            tick();
        end
        chk32("t4_cycles", 32'(cnt), 32'd15);
        chk1("t4_m0_ack", m0_ack, 1'b1);
        chk1("t4_m0_err", m0_err, 1'b1);
        chk32("t4_m0_rdata", m0_rdata, 32'h0);
        chk1("t4_s_req", s_req, 1'b0);
        m0_req = 1'b0;
        repeat (2) tick();
        m0_req = 1'b1;
        wait_sreq("t4b_grant", ok);
        repeat (14) tick();
        s_ack = 1'b1; s_rdata = 32'h0BAD_F00D;
        tick();
        s_ack = 1'b0;
        chk1("t4b_m0_ack", m0_ack, 1'b1);
        chk1("t4b_m0_err", m0_err, 1'b0);
        chk32("t4b_m0_rdata", m0_rdata, 32'h0BAD_F00D);
        m0_req = 1'b0;
        repeat (2) tick();
`endif

        // Reset in the middle of WAIT
        m0_req = 1'b1; m0_rnw = 1'b1; m0_addr = 32'h0000_0100;
        wait_sreq("t5_grant", ok);
        repeat (2) tick();
        chk1("t5_busy_pre", busy, 1'b1);
        rst = 1'b1; m1_req = 1'b1; m1_addr = 32'h0000_0200;
        tick();
        rst = 1'b0;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_s_req", s_req, 1'b0);
        chk1("t5_m0_ack", m0_ack, 1'b0);
        chk1("t5_owner", owner, 1'b0);
        serve("t5_tie", 1'b0, 32'h0000_0100);
        m0_req = 1'b0;
        serve("t5_next", 1'b1, 32'h0000_0200);
        m1_req = 1'b0;
        repeat (2) tick();

        // Spurious slave ack while idle
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_s_req", s_req, 1'b0);
        chk1("t6_m0_ack", m0_ack, 1'b0);
        chk1("t6_m1_ack", m1_ack, 1'b0);
        tick();
        chk1("t6_busy_after", busy, 1'b0);

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drive_m(md_ack_cyc && !md_owner, m0_req, m0_rnw, m0_addr, m0_wdata);
            drive_m(md_ack_cyc && md_owner, m1_req, m1_rnw, m1_addr, m1_wdata);
            s_ack   = md_tx ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            s_rdata = $urandom;
            rst     = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; s_ack = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
